// File: rtl/byter_pkg.sv
// Shared types and constants for the round-robin byte-serializing arbiter.
// The word is always 8 bytes, so the byte counter is 3 bits wide.
package byter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int BYTES_PER_WORD = 8;
  localparam int BYTE_W         = 8;
  localparam int CNT_W          = $clog2(BYTES_PER_WORD);

  localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin picker: the search starts at i_ptr and wraps past N_REQ-1 to 0.
// Returns a one-hot grant, its index and whether any request was seen.
module rr_arbiter #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         i_req,
  input  logic [$clog2(N_REQ)-1:0] i_ptr,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grantIdx,
  output logic                     o_any
);

  localparam int IDX_W = $clog2(N_REQ);

  // The candidate index is narrowed to IDX_W bits before it is used as a select.
  always_comb begin
    int                 w_cand;
    logic [IDX_W-1:0]   w_candIdx;
    o_grant    = '0;
    o_grantIdx = '0;
    o_any      = 1'b0;
    w_cand     = 0;
    w_candIdx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_cand = int'(i_ptr) + k;
      if (w_cand >= N_REQ) begin
        w_cand = w_cand - N_REQ;
      end
      w_candIdx = IDX_W'(w_cand);
      if (!o_any && i_req[w_candIdx]) begin
        o_any               = 1'b1;
        o_grant[w_candIdx]  = 1'b1;
        o_grantIdx          = w_candIdx;
      end
    end
  end

endmodule

// File: rtl/byter_arbiter.sv
// Grants one of N_REQ requesters round-robin, latches its 64-bit word and
// streams it out LSB byte first under out_ready backpressure.
module byter_arbiter
  import byter_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int WORD_W = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*WORD_W-1:0]   req_data,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BYTE_W-1:0]         byte_out,
  output logic                      data_ready,
  input  logic                      out_ready,
  output logic                      byte_last,
  output logic [$clog2(N_REQ)-1:0]  src_id,
  output logic                      busy
);

  localparam int IDX_W = $clog2(N_REQ);

  state_t             r_state;
  state_t             w_stateNext;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_srcId;
  logic [WORD_W-1:0]  r_word;
  logic [CNT_W-1:0]   r_byteCnt;

  logic [N_REQ-1:0]   w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;
  logic               w_fire;
  logic               w_accept;
  logic [WORD_W-1:0]  w_selWord;
  logic [BYTE_W-1:0]  w_byte;
  logic [IDX_W-1:0]   w_ptrNext;

  rr_arbiter #(.N_REQ(N_REQ)) u_rr (
    .i_req      (req_valid),
    .i_ptr      (r_ptr),
    .o_grant    (w_grant),
    .o_grantIdx (w_idx),
    .o_any      (w_any)
  );

  always_comb begin
    w_selWord = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_idx == IDX_W'(i)) begin
        w_selWord = req_data[i*WORD_W +: WORD_W];
      end
    end
  end

  always_comb begin
    w_byte = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (r_byteCnt == CNT_W'(b)) begin
        w_byte = r_word[b*BYTE_W +: BYTE_W];
      end
    end
  end

  assign w_ptrNext = (w_idx == IDX_W'(N_REQ - 1)) ? '0 : w_idx + 1'b1;

  // A grant is suppressed while rst is high so no req_ready pulse escapes reset.
  always_comb begin
    w_stateNext = r_state;
    w_fire      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (enable && w_any && !rst) begin
          w_fire      = 1'b1;
          w_stateNext = SEND;
        end
      end
      SEND: begin
        w_accept = out_ready;
        if (out_ready && (r_byteCnt == LAST_BYTE)) begin
          w_stateNext = IDLE;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_ptr     <= '0;
      r_srcId   <= '0;
      r_word    <= '0;
      r_byteCnt <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_fire) begin
        r_word    <= w_selWord;
        r_srcId   <= w_idx;
        r_ptr     <= w_ptrNext;
        r_byteCnt <= '0;
      end else if (w_accept) begin
        r_byteCnt <= (r_byteCnt == LAST_BYTE) ? '0 : r_byteCnt + 1'b1;
      end
    end
  end

  assign busy       = (r_state == SEND);
  assign data_ready = busy;
  assign req_ready  = w_fire ? w_grant : '0;
  assign byte_out   = busy ? w_byte : '0;
  assign byte_last  = busy && (r_byteCnt == LAST_BYTE);
  assign src_id     = r_srcId;

endmodule

// File: tb/tb_byter_arbiter.sv
// Self-checking bench for byter_arbiter: a cycle model plus a byte scoreboard
// run on every cycle, with a vector table and directed corner-case sequences.
module tb_byter_arbiter;

  localparam int N_REQ  = 4;
  localparam int WORD_W = 64;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     enable;
  logic                     out_ready;
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ-1:0]         req_ready;
  logic [N_REQ*WORD_W-1:0]  req_data;
  logic [7:0]               byte_out;
  logic                     data_ready;
  logic                     byte_last;
  logic [1:0]               src_id;
  logic                     busy;

  always #5 clk = ~clk;

  byter_arbiter #(.N_REQ(N_REQ), .WORD_W(WORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .byte_out   (byte_out),
    .data_ready (data_ready),
    .out_ready  (out_ready),
    .byte_last  (byte_last),
    .src_id     (src_id),
    .busy       (busy)
  );

  int checks = 0;
  int errors = 0;

  logic        mBusy;
  logic [2:0]  mCnt;
  logic [1:0]  mPtr;
  logic [1:0]  mSrc;
  logic [63:0] mWord;

  typedef struct packed {
    logic [1:0] src;
    logic [7:0] data;
    logic       last;
  } sbEntry_t;
  sbEntry_t sbQ[$];

  logic [N_REQ-1:0] sReady;
  logic             sDataReady;
  logic [7:0]       sByte;
  logic             sLast;
  logic [1:0]       sSrc;

  typedef struct {
    logic       r;
    logic       en;
    logic [3:0] v;
    logic       ordy;
    logic [3:0] eReady;
    logic       eDr;
    logic [7:0] eByte;
    logic       eLast;
  } vec_t;
  vec_t vecs[11];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40) $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int modelPick(input logic [N_REQ-1:0] v, input logic [1:0] p);
    for (int k = 0; k < N_REQ; k++) begin
      int j;
      j = (int'(p) + k) % N_REQ;
      if (v[j]) return j;
    end
    return -1;
  endfunction

  // One clock: drive inputs, sample at negedge against the model, advance model at posedge.
  task automatic applyStimulus(input logic r, input logic en, input logic [N_REQ-1:0] v, input logic ordy);
    int               g;
    logic             fire;
    logic [N_REQ-1:0] expReady;
    sbEntry_t         e;
    rst = r; enable = en; req_valid = v; out_ready = ordy;
    @(negedge clk);
    sReady = req_ready; sDataReady = data_ready; sByte = byte_out; sLast = byte_last; sSrc = src_id;
    g = modelPick(v, mPtr);
    fire = !mBusy && en && (g >= 0) && !r;
    expReady = '0;
    if (fire) expReady[g] = 1'b1;
    checkOutput("req_ready", req_ready, expReady);
    checkOutput("data_ready", data_ready, mBusy);
    checkOutput("busy", busy, mBusy);
    checkOutput("byte_out", byte_out, mBusy ? mWord[8*mCnt +: 8] : 8'h00);
    checkOutput("byte_last", byte_last, mBusy && (mCnt == 3'd7));
    checkOutput("src_id", src_id, mSrc);
    if (!r && data_ready && ordy) begin
      if (sbQ.size() == 0) begin
        checkOutput("sb_unexpected_byte", 1, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb_byte", byte_out, e.data);
        checkOutput("sb_src", src_id, e.src);
        checkOutput("sb_last", byte_last, e.last);
      end
    end
    @(posedge clk);
    if (r) begin
      mBusy = 1'b0; mCnt = '0; mPtr = '0; mSrc = '0; mWord = '0;
      sbQ.delete();
    end else if (fire) begin
      mBusy = 1'b1; mCnt = '0; mSrc = 2'(g);
      mWord = req_data[g*WORD_W +: WORD_W];
      mPtr = 2'((g + 1) % N_REQ);
      for (int b = 0; b < 8; b++) sbQ.push_back('{src: 2'(g), data: mWord[8*b +: 8], last: (b == 7)});
    end else if (mBusy && ordy) begin
      if (mCnt == 3'd7) begin
        mBusy = 1'b0; mCnt = '0;
      end else begin
        mCnt = mCnt + 3'd1;
      end
    end
    #1;
  endtask

  function automatic int oneHotIdx(input logic [N_REQ-1:0] oh);
    for (int i = 0; i < N_REQ; i++) if (oh[i]) return i;
    return -1;
  endfunction

  initial begin
    int grantIdx[$];
    int grantCyc[$];
    int cnt;
    int drCount;

    rst = 1'b1; enable = 1'b0; out_ready = 1'b0; req_valid = '0;
    req_data = '0;
    req_data[0*64 +: 64] = 64'h0807060504030201;
    req_data[1*64 +: 64] = 64'h1817161514131211;
    req_data[2*64 +: 64] = 64'h2827262524232221;
    req_data[3*64 +: 64] = 64'h3837363534333231;
    repeat (2) @(posedge clk);
    #1;
    mBusy = 1'b0; mCnt = '0; mPtr = '0; mSrc = '0; mWord = '0;

    $display("[TB] single word vector table");
    vecs[0] = '{1'b1, 1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b1, 4'b0001, 1'b1, 4'b0001, 1'b0, 8'h00, 1'b0};
    for (int k = 2; k <= 9; k++) vecs[k] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 8'(k - 1), (k == 9)};
    vecs[10] = '{1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 8'h00, 1'b0};
    for (int k = 0; k < 11; k++) begin
      applyStimulus(vecs[k].r, vecs[k].en, vecs[k].v, vecs[k].ordy);
      checkOutput("vec_req_ready", sReady, vecs[k].eReady);
      checkOutput("vec_data_ready", sDataReady, vecs[k].eDr);
      checkOutput("vec_byte_out", sByte, vecs[k].eByte);
      checkOutput("vec_byte_last", sLast, vecs[k].eLast);
      if (vecs[k].eDr) checkOutput("vec_src_id", sSrc, 0);
    end

    $display("[TB] round-robin");
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int c = 0; c < 40; c++) begin
      applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
      if (sReady != 0) begin
        grantIdx.push_back(oneHotIdx(sReady));
        grantCyc.push_back(c);
      end
    end
    checkOutput("rr_grant_count", grantIdx.size(), 5);
    for (int i = 0; i < 5 && i < grantIdx.size(); i++) begin
      checkOutput("rr_grant_order", grantIdx[i], i % 4);
      checkOutput("rr_grant_cycle", grantCyc[i], 9 * i);
    end

    $display("[TB] backpressure");
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0001, 1'b1);
    checkOutput("bp_grant", sReady, 4'b0001);
    drCount = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b1, 4'b0000, !(i >= 2 && i <= 4));
      if (sDataReady) drCount++;
      if (i >= 2 && i <= 4) begin
        checkOutput("bp_hold_byte", sByte, 8'h03);
        checkOutput("bp_hold_valid", sDataReady, 1'b1);
      end
    end
    checkOutput("bp_byte_cycles", drCount, 11);

    $display("[TB] enable gating");
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);
      if (sReady != 0) cnt++;
    end
    checkOutput("en_no_grant", cnt, 0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
    checkOutput("en_grant", sReady, 4'b0001);
    cnt = 0; drCount = 0;
    for (int i = 0; i < 25; i++) begin
      applyStimulus(1'b0, 1'b0, 4'b1111, 1'b1);
      if (sReady != 0) cnt++;
      if (sDataReady) drCount++;
    end
    checkOutput("en_drop_no_grant", cnt, 0);
    checkOutput("en_drop_completes", drCount, 8);

    $display("[TB] reset mid-word");
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    applyStimulus(1'b0, 1'b1, 4'b0010, 1'b1);
    checkOutput("rst_first_grant", sReady, 4'b0010);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 4'b0000, 1'b1);
    applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0);
    checkOutput("rst_no_grant_in_reset", sReady, 4'b0000);
    applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
    checkOutput("rst_data_ready_low", sDataReady, 1'b0);
    applyStimulus(1'b0, 1'b1, 4'b1111, 1'b1);
    checkOutput("rst_grant_req0", sReady, 4'b0001);
    for (int i = 0; i < 9; i++) applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);

    $display("[TB] random stress");
    applyStimulus(1'b1, 1'b0, 4'b0000, 1'b1);
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_data[$urandom_range(0, N_REQ - 1)*64 +: 64] = {$urandom, $urandom};
      end
      applyStimulus(1'b0, $urandom_range(0, 7) != 0, 4'($urandom), $urandom_range(0, 3) != 0);
    end
    checkOutput("sb_residue", sbQ.size(), mBusy ? (8 - int'(mCnt)) : 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
